// File: rtl/lpc_decoder.sv
// Purpose: 2-D parity decoder that corrects single-bit errors and re-serialises 8 data bytes as 4 x 16-bit stream beats.
// Latency: a codeword accepted in cycle t has beat 0 valid in cycle t+2; a back-to-back codeword period is at least 6 cycles.
// Backpressure: IN_READY is high only in IDLE; beats hold stable while TREADY is low, and no new codeword is taken until beat 3 handshakes.
module lpc_decoder #(
    parameter int          CNT_W       = 16,
    parameter int unsigned DROP_UNCORR = 0
) (
    input  logic             ACLK,
    input  logic             ARESET_N,
    input  logic [79:0]      IN_DATA,
    input  logic             IN_VALID,
    input  logic             IN_LAST,
    input  logic             IN_USER,
    output logic             IN_READY,
    output logic [15:0]      TDATA,
    output logic             TVALID,
    output logic             TLAST,
    output logic             TUSER,
    input  logic             TREADY,
    output logic             ERR_CORR,
    output logic             ERR_UNCORR,
    output logic [CNT_W-1:0] CORR_CNT,
    output logic [CNT_W-1:0] UNCORR_CNT,
    input  logic             CNT_CLR
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_SEND   = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Captured codeword fields; src_q is corrected in place during DECODE.
    logic [63:0] src_q;
    logic [7:0]  pv_q;
    logic [7:0]  ph_q;
    logic        last_q;
    logic        user_q;
    logic [1:0]  beat;

    logic        err_corr_q;
    logic        err_uncorr_q;
    logic [CNT_W-1:0] corr_cnt_q;
    logic [CNT_W-1:0] uncorr_cnt_q;

    // Syndrome and correction terms, only meaningful while in DECODE.
    logic [7:0]  row_syn;
    logic [7:0]  col_syn;
    logic        data_err;
    logic        par_err;
    logic        syn_clean;
    logic        uncorr;
    logic [63:0] flip_mask;
    logic        dec_corr;
    logic        dec_uncorr;

    logic        accept;
    logic        beat_hs;
    logic [5:0]  lo_idx;

    function automatic logic onehot8(input logic [7:0] v);
        return (v != 8'h00) && ((v & (v - 8'd1)) == 8'h00);
    endfunction

    // Row/column syndromes and the single data-bit flip mask they imply.
    always_comb begin
        row_syn   = 8'h00;
        col_syn   = ph_q;
        flip_mask = 64'h0;
        for (int i = 0; i < 8; i++) begin
            row_syn[i] = pv_q[i] ^ (^src_q[8*i +: 8]);
            col_syn    = col_syn ^ src_q[8*i +: 8];
        end
        syn_clean = (row_syn == 8'h00) && (col_syn == 8'h00);
        data_err  = onehot8(row_syn) && onehot8(col_syn);
        // A lone row or lone column hit means the parity bit itself flipped.
        par_err   = (onehot8(row_syn) && (col_syn == 8'h00)) ||
                    ((row_syn == 8'h00) && onehot8(col_syn));
        uncorr    = !syn_clean && !data_err && !par_err;
        for (int i = 0; i < 8; i++) begin
            if (data_err && row_syn[i]) begin
                flip_mask[8*i +: 8] = col_syn;
            end
        end
        dec_corr   = (state == S_DECODE) && (data_err || par_err);
        dec_uncorr = (state == S_DECODE) && uncorr;
    end

    // State register.
    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and stream-side outputs.
    always_comb begin
        state_nxt = state;
        IN_READY  = 1'b0;
        TVALID    = 1'b0;
        TDATA     = 16'h0000;
        TUSER     = 1'b0;
        TLAST     = 1'b0;
        lo_idx    = {beat, 4'b0000};
        case (state)
            S_IDLE: begin
                IN_READY = 1'b1;
                if (IN_VALID) begin
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (uncorr && (DROP_UNCORR != 0)) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                TVALID = 1'b1;
                TDATA  = {src_q[lo_idx +: 8], src_q[(lo_idx + 6'd8) +: 8]};
                TUSER  = user_q && (beat == 2'd0);
                TLAST  = last_q && (beat == 2'd3);
                if (TREADY && (beat == 2'd3)) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign accept  = (state == S_IDLE) && IN_VALID;
    assign beat_hs = (state == S_SEND) && TREADY;

    // Codeword capture, in-place correction and beat counter.
    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            src_q  <= 64'h0;
            pv_q   <= 8'h00;
            ph_q   <= 8'h00;
            last_q <= 1'b0;
            user_q <= 1'b0;
            beat   <= 2'd0;
        end else if (accept) begin
            src_q  <= IN_DATA[63:0];
            pv_q   <= IN_DATA[71:64];
            ph_q   <= IN_DATA[79:72];
            last_q <= IN_LAST;
            user_q <= IN_USER;
            beat   <= 2'd0;
        end else if (state == S_DECODE) begin
            src_q <= src_q ^ flip_mask;
        end else if (beat_hs) begin
            beat <= beat + 2'd1;
        end
    end

    // One-cycle error pulses, landing in the cycle after DECODE.
    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            err_corr_q   <= 1'b0;
            err_uncorr_q <= 1'b0;
        end else begin
            err_corr_q   <= dec_corr;
            err_uncorr_q <= dec_uncorr;
        end
    end

    // Saturating event counters; a clear wins over a same-cycle event.
    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else if (CNT_CLR) begin
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            if (dec_corr && (corr_cnt_q != '1)) begin
                corr_cnt_q <= corr_cnt_q + CNT_W'(1);
            end
            if (dec_uncorr && (uncorr_cnt_q != '1)) begin
                uncorr_cnt_q <= uncorr_cnt_q + CNT_W'(1);
            end
        end
    end

    assign ERR_CORR   = err_corr_q;
    assign ERR_UNCORR = err_uncorr_q;
    assign CORR_CNT   = corr_cnt_q;
    assign UNCORR_CNT = uncorr_cnt_q;

endmodule

// File: tb/tb_lpc_decoder.sv
// Purpose: randomized and directed bench for lpc_decoder against a nearest-codeword reference model.
// Latency: expects beat 0 two cycles after acceptance and error pulses in the cycle after DECODE.
// Backpressure: drives TREADY always-on, 1010 toggling, or random, and checks outputs hold during stalls.
module tb_lpc_decoder;

    logic        ACLK = 1'b0;
    logic        arst_n;
    logic [79:0] in_data;
    logic [1:0]  in_valid;
    logic        in_last;
    logic        in_user;
    logic        tready;
    logic        cnt_clr;
    logic [1:0]  in_ready, tvalid, tlast, tuser, err_corr, err_uncorr;
    logic [15:0] tdata0, tdata1;
    logic [15:0] ccnt0, ucnt0;
    logic [1:0]  ccnt1, ucnt1;

    int checks = 0;
    int errors = 0;
    int unsigned mc_corr [2];
    int unsigned mc_unc  [2];
    int unsigned cmax    [2];

    always #5 ACLK = ~ACLK;

    lpc_decoder #(.CNT_W(16), .DROP_UNCORR(0)) u_dut0 (
        .ACLK(ACLK), .ARESET_N(arst_n), .IN_DATA(in_data), .IN_VALID(in_valid[0]),
        .IN_LAST(in_last), .IN_USER(in_user), .IN_READY(in_ready[0]), .TDATA(tdata0),
        .TVALID(tvalid[0]), .TLAST(tlast[0]), .TUSER(tuser[0]), .TREADY(tready),
        .ERR_CORR(err_corr[0]), .ERR_UNCORR(err_uncorr[0]), .CORR_CNT(ccnt0),
        .UNCORR_CNT(ucnt0), .CNT_CLR(cnt_clr)
    );

    lpc_decoder #(.CNT_W(2), .DROP_UNCORR(1)) u_dut1 (
        .ACLK(ACLK), .ARESET_N(arst_n), .IN_DATA(in_data), .IN_VALID(in_valid[1]),
        .IN_LAST(in_last), .IN_USER(in_user), .IN_READY(in_ready[1]), .TDATA(tdata1),
        .TVALID(tvalid[1]), .TLAST(tlast[1]), .TUSER(tuser[1]), .TREADY(tready),
        .ERR_CORR(err_corr[1]), .ERR_UNCORR(err_uncorr[1]), .CORR_CNT(ccnt1),
        .UNCORR_CNT(ucnt1), .CNT_CLR(cnt_clr)
    );

    function automatic logic [15:0] o_tdata(input int d);
        return (d == 0) ? tdata0 : tdata1;
    endfunction

    function automatic logic [15:0] o_ccnt(input int d);
        return (d == 0) ? ccnt0 : {14'h0, ccnt1};
    endfunction

    function automatic logic [15:0] o_ucnt(input int d);
        return (d == 0) ? ucnt0 : {14'h0, ucnt1};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A codeword is valid when every byte matches its pv bit and ph is the XOR of all bytes.
    function automatic bit cw_ok(input logic [79:0] cw);
        logic [7:0] col;
        col = cw[79:72];
        for (int i = 0; i < 8; i++) begin
            if ((^cw[8*i +: 8]) != cw[64+i]) return 1'b0;
            col = col ^ cw[8*i +: 8];
        end
        return col == 8'h00;
    endfunction

    function automatic logic [79:0] encode(input logic [63:0] d);
        logic [7:0] ph;
        logic [7:0] pv;
        ph = 8'h00;
        for (int i = 0; i < 8; i++) begin
            ph    = ph ^ d[8*i +: 8];
            pv[i] = ^d[8*i +: 8];
        end
        return {ph, pv, d};
    endfunction

    function automatic logic [79:0] flip(input logic [79:0] cw, input int b);
        logic [79:0] one;
        one = 80'd1;
        return cw ^ (one << b);
    endfunction

    // Reference: a received word within distance 1 of exactly one valid codeword is correctable.
    function automatic void model(input logic [79:0] cw, output logic [63:0] data,
                                  output bit corr, output bit unc);
        int n;
        logic [79:0] fix;
        logic [79:0] t;
        data = cw[63:0];
        corr = 1'b0;
        unc  = 1'b0;
        n    = 0;
        fix  = cw;
        if (!cw_ok(cw)) begin
            for (int b = 0; b < 80; b++) begin
                t = flip(cw, b);
                if (cw_ok(t)) begin
                    n++;
                    fix = t;
                end
            end
            if (n == 1) begin
                corr = 1'b1;
                data = fix[63:0];
            end else begin
                unc = 1'b1;
            end
        end
    endfunction

    task automatic check_reset(input int d);
        check("rst_in_ready", in_ready[d], 1);
        check("rst_tvalid", tvalid[d], 0);
        check("rst_tlast", tlast[d], 0);
        check("rst_tuser", tuser[d], 0);
        check("rst_tdata", o_tdata(d), 0);
        check("rst_err_corr", err_corr[d], 0);
        check("rst_err_uncorr", err_uncorr[d], 0);
        check("rst_corr_cnt", o_ccnt(d), 0);
        check("rst_uncorr_cnt", o_ucnt(d), 0);
    endtask

    // mode: 0 always ready, 1 toggling 1010, 2 random with input noise.
    task automatic run_cw(input int d, input logic [79:0] cw, input bit usr, input bit lst,
                          input int mode, input int abort_beat, input bit clr);
        logic [63:0] ed;
        bit ec, eu, tr;
        int k, cyc;
        model(cw, ed, ec, eu);
        @(negedge ACLK);
        cyc = 0;
        while (!in_ready[d] && cyc < 50) begin
            @(negedge ACLK);
            cyc++;
        end
        check("in_ready_idle", in_ready[d], 1);
        in_data     = cw;
        in_user     = usr;
        in_last     = lst;
        in_valid[d] = 1'b1;
        @(posedge ACLK);
        #1;
        in_valid[d] = (mode == 2) ? 1'($urandom % 2) : 1'b0;
        in_data     = {16'($urandom), $urandom, $urandom};
        cnt_clr     = clr;
        @(negedge ACLK);
        check("decode_in_ready", in_ready[d], 0);
        check("decode_tvalid", tvalid[d], 0);
        @(posedge ACLK);
        #1;
        cnt_clr     = 1'b0;
        in_valid[d] = 1'b0;
        if (clr) begin
            mc_corr[d] = 0;
            mc_unc[d]  = 0;
        end else begin
            if (ec && mc_corr[d] < cmax[d]) mc_corr[d]++;
            if (eu && mc_unc[d] < cmax[d]) mc_unc[d]++;
        end
        @(negedge ACLK);
        check("err_corr_pulse", err_corr[d], ec);
        check("err_uncorr_pulse", err_uncorr[d], eu);
        check("corr_cnt", o_ccnt(d), mc_corr[d]);
        check("uncorr_cnt", o_ucnt(d), mc_unc[d]);
        if (eu && d == 1) begin
            check("drop_tvalid", tvalid[d], 0);
            check("drop_in_ready", in_ready[d], 1);
            return;
        end
        k   = 0;
        cyc = 0;
        while (k < 4 && cyc < 200) begin
            check("beat_tvalid", tvalid[d], 1);
            check("beat_tdata", o_tdata(d), {ed[16*k +: 8], ed[16*k+8 +: 8]});
            check("beat_tuser", tuser[d], usr && (k == 0));
            check("beat_tlast", tlast[d], lst && (k == 3));
            check("beat_in_ready", in_ready[d], 0);
            if (cyc > 0) check("err_pulse_width", err_corr[d] | err_uncorr[d], 0);
            if (abort_beat == k) begin
                arst_n = 1'b0;
                #1;
                mc_corr[0] = 0; mc_unc[0] = 0;
                mc_corr[1] = 0; mc_unc[1] = 0;
                check_reset(d);
                #2;
                arst_n      = 1'b1;
                tready      = 1'b0;
                in_valid[d] = 1'b0;
                return;
            end
            tr = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom % 2);
            tready      = tr;
            in_valid[d] = (mode == 2 && k < 3) ? 1'($urandom % 2) : 1'b0;
            @(negedge ACLK);
            if (tr) k++;
            cyc++;
        end
        check("beats_done", k, 4);
        tready      = 1'b0;
        in_valid[d] = 1'b0;
        check("end_tvalid", tvalid[d], 0);
        check("end_in_ready", in_ready[d], 1);
    endtask

    task automatic run_random(input int d, input int n);
        logic [79:0] cw;
        int nf, b0, b1;
        for (int i = 0; i < n; i++) begin
            cw = encode({$urandom, $urandom});
            nf = int'($urandom % 3);
            b0 = int'($urandom % 80);
            b1 = (b0 + 1 + int'($urandom % 79)) % 80;
            if (nf >= 1) cw = flip(cw, b0);
            if (nf == 2) cw = flip(cw, b1);
            run_cw(d, cw, 1'($urandom % 2), 1'($urandom % 2), int'($urandom % 3), -1, 1'b0);
        end
    endtask

    logic [79:0] base;
    logic [79:0] two_err;

    initial begin
        mc_corr[0] = 0; mc_unc[0] = 0; mc_corr[1] = 0; mc_unc[1] = 0;
        cmax[0] = 65535; cmax[1] = 3;
        arst_n   = 1'b1;
        in_data  = 80'h0;
        in_valid = 2'b00;
        in_last  = 1'b0;
        in_user  = 1'b0;
        tready   = 1'b0;
        cnt_clr  = 1'b0;
        #2 arst_n = 1'b0;
        #10;
        check_reset(0);
        check_reset(1);
        @(negedge ACLK);
        arst_n = 1'b1;

        base    = encode(64'h0807060504030201);
        two_err = flip(flip(base, 16), 40);

        // Clean, data-bit, pv-bit, ph-bit and double errors on the forwarding decoder.
        run_cw(0, base, 1'b0, 1'b0, 0, -1, 1'b0);
        run_cw(0, flip(base, 20), 1'b0, 1'b0, 0, -1, 1'b0);
        run_cw(0, flip(base, 64), 1'b0, 1'b0, 0, -1, 1'b0);
        run_cw(0, flip(base, 72), 1'b0, 1'b0, 0, -1, 1'b0);
        run_cw(0, two_err, 1'b0, 1'b0, 0, -1, 1'b0);
        // Framing flags under 1010 backpressure.
        run_cw(0, base, 1'b1, 1'b1, 1, -1, 1'b0);
        // Reset during beat 1, then a normal codeword.
        run_cw(0, flip(base, 20), 1'b1, 1'b1, 0, 1, 1'b0);
        run_cw(0, base, 1'b1, 1'b0, 0, -1, 1'b0);
        // Clear racing an error event.
        run_cw(0, flip(base, 5), 1'b0, 1'b0, 0, -1, 1'b0);
        run_cw(0, flip(base, 5), 1'b0, 1'b0, 0, -1, 1'b1);
        run_random(0, 12);

        // Dropping decoder with 2-bit counters: drop, saturation and clear priority.
        for (int i = 0; i < 4; i++) run_cw(1, two_err, 1'b0, 1'b1, 0, -1, 1'b0);
        for (int i = 0; i < 4; i++) run_cw(1, flip(base, 3 + i), 1'b1, 1'b1, 0, -1, 1'b0);
        run_cw(1, two_err, 1'b0, 1'b0, 0, -1, 1'b1);
        run_cw(1, base, 1'b1, 1'b1, 1, -1, 1'b0);
        run_random(1, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #500000;
        $display("FAIL timeout: observed no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
